// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU encodings, aluop classes, skid FSM states and the aluoperation decoder
// for the execute-issue stage.
package alu_issue_stage_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_ILL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [2:0] op;
      logic       illegal;
   } dec_t;

   function automatic dec_t alu_decode(input logic [1:0] aluop,
                                       input logic [2:0] funct3,
                                       input logic       funct7_5);
      dec_t d;
      d.op      = ALU_ILL;
      d.illegal = 1'b1;
      case (aluop)
         ALUOP_MEM: begin
            d.op      = ALU_ADD;
            d.illegal = 1'b0;
         end
         ALUOP_BRANCH: begin
            d.op      = ALU_SUB;
            d.illegal = 1'b0;
         end
         ALUOP_RTYPE, ALUOP_ITYPE: begin
            d.illegal = 1'b0;
            case (funct3)
               // Immediate forms have no subtract, so bit 30 only matters for R-type.
               3'b000:  d.op = (aluop == ALUOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b111:  d.op = ALU_AND;
               3'b110:  d.op = ALU_OR;
               3'b010:  d.op = ALU_SLT;
               default: begin
                  d.op      = ALU_ILL;
                  d.illegal = 1'b1;
               end
            endcase
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Per-operand forwarding select: EX/MEM over MEM/WB over register file; x0 never forwarded.
module alu_issue_stage_fwd_mux #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic [RADDR-1:0] rs,
   input  logic [XLEN-1:0]  rf_data,
   input  logic             exm_regwrite,
   input  logic [RADDR-1:0] exm_rd,
   input  logic [XLEN-1:0]  exm_result,
   input  logic             wb_regwrite,
   input  logic [RADDR-1:0] wb_rd,
   input  logic [XLEN-1:0]  wb_result,
   output logic [XLEN-1:0]  data
);

   always_comb begin
      // NOTE: give every always_comb output a default first so no path infers a latch.
      data = rf_data;
      if (rs != '0) begin
         if (exm_regwrite && exm_rd == rs)     data = exm_result;
         else if (wb_regwrite && wb_rd == rs)  data = wb_result;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: forwards operands, decodes aluoperation and holds results in a
// 2-entry skid buffer (main + skid) feeding the ALU.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       aluop,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic             alusrc,
   input  logic [RADDR-1:0] rs1,
   input  logic [RADDR-1:0] rs2,
   input  logic [RADDR-1:0] rd,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic [XLEN-1:0]  imm,
   input  logic             regwrite,
   input  logic             exm_regwrite,
   input  logic [RADDR-1:0] exm_rd,
   input  logic [XLEN-1:0]  exm_result,
   input  logic             wb_regwrite,
   input  logic [RADDR-1:0] wb_rd,
   input  logic [XLEN-1:0]  wb_result,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  a,
   output logic [XLEN-1:0]  b,
   output logic [2:0]       aluoperation,
   output logic [RADDR-1:0] out_rd,
   output logic             out_regwrite,
   output logic             illegal
);

   typedef struct packed {
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [2:0]       op;
      logic [RADDR-1:0] rd;
      logic             regwrite;
      logic             illegal;
   } entry_t;

   logic [XLEN-1:0] fwd_a, fwd_b;
   dec_t            dec;
   entry_t          incoming;

   alu_issue_stage_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_a (
      .rs(rs1), .rf_data(rs1_data),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
      .data(fwd_a)
   );

   alu_issue_stage_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_b (
      .rs(rs2), .rf_data(rs2_data),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
      .data(fwd_b)
   );

   assign dec = alu_decode(aluop, funct3, funct7_5);

   always_comb begin
      incoming.a        = fwd_a;
      incoming.b        = alusrc ? imm : fwd_b;
      incoming.op       = dec.op;
      incoming.rd       = rd;
      incoming.regwrite = regwrite & ~dec.illegal;
      incoming.illegal  = dec.illegal;
   end

   state_e state_q, state_d;
   entry_t main_q, main_d, skid_q, skid_d;
   logic   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic   accept, fire;

   assign accept = in_valid & in_ready_q & ~flush;
   assign fire   = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) begin
               main_d  = incoming;
               state_d = ST_ONE;
            end
            ST_ONE: begin
               if (accept && fire) begin
                  main_d = incoming;
               end else if (accept) begin
                  skid_d  = incoming;
                  state_d = ST_TWO;
               end else if (fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: if (fire) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // NOTE: the entry registers are reset too, since every output must read 0 out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign a            = main_q.a;
   assign b            = main_q.b;
   assign aluoperation = main_q.op;
   assign out_rd       = main_q.rd;
   assign out_regwrite = main_q.regwrite;
   assign illegal      = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode/forwarding vector table plus skid, flush
// and reset sequences.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [1:0]  aluop;
   logic [2:0]  funct3;
   logic        funct7_5, alusrc;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rs1_data, rs2_data, imm;
   logic        regwrite;
   logic        exm_regwrite;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic        flush, out_valid, out_ready;
   logic [31:0] a, b;
   logic [2:0]  aluoperation;
   logic [4:0]  out_rd;
   logic        out_regwrite, illegal;

   alu_issue_stage #(.XLEN(32), .RADDR(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .funct3(funct3), .funct7_5(funct7_5), .alusrc(alusrc),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .regwrite(regwrite),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .b(b), .aluoperation(aluoperation), .out_rd(out_rd),
      .out_regwrite(out_regwrite), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  aluop;
      logic [2:0]  f3;
      logic        f7;
      logic        alusrc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rs1_data, rs2_data, imm;
      logic        regwrite;
      logic        exm_rw;
      logic [4:0]  exm_rd;
      logic [31:0] exm_res;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [31:0] wb_res;
      logic [31:0] exp_a, exp_b;
      logic [2:0]  exp_op;
      logic        exp_ill;
      logic        exp_rw;
   } vec_t;

   vec_t vecs[11];
   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      in_valid     = 1'b1;
      aluop        = v.aluop;    funct3   = v.f3;       funct7_5 = v.f7;
      alusrc       = v.alusrc;   rs1      = v.rs1;      rs2      = v.rs2;
      rd           = v.rd;       rs1_data = v.rs1_data; rs2_data = v.rs2_data;
      imm          = v.imm;      regwrite = v.regwrite;
      exm_regwrite = v.exm_rw;   exm_rd   = v.exm_rd;   exm_result = v.exm_res;
      wb_regwrite  = v.wb_rw;    wb_rd    = v.wb_rd;    wb_result  = v.wb_res;
   endtask

   // Plain load/store-add instruction tagged by rs1 data and rd.
   task automatic drive_simple(input logic [31:0] d, input logic [4:0] tag);
      in_valid = 1'b1;  aluop = 2'b00;  funct3 = 3'b000;  funct7_5 = 1'b0;
      alusrc = 1'b0;  rs1 = 5'd1;  rs2 = 5'd2;  rd = tag;
      rs1_data = d;  rs2_data = 32'd0;  imm = 32'd0;  regwrite = 1'b1;
      exm_regwrite = 1'b0;  wb_regwrite = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, 1'b1,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd9, 32'd4, 3'b001, 1'b0, 1'b1};
      vecs[1]  = '{2'b00, 3'b010, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 32'h99, 32'h5, 32'h40, 1'b1,
                   1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h11, 32'h40, 3'b000, 1'b0, 1'b1};
      vecs[2]  = '{2'b00, 3'b000, 1'b0, 1'b1, 5'd0, 5'd6, 5'd7, 32'h77, 32'h5, 32'h40, 1'b1,
                   1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 32'h77, 32'h40, 3'b000, 1'b0, 1'b1};
      vecs[3]  = '{2'b01, 3'b000, 1'b0, 1'b0, 5'd3, 5'd6, 5'd8, 32'h10, 32'h5, 32'd0, 1'b0,
                   1'b0, 5'd6, 32'h11, 1'b1, 5'd6, 32'h22, 32'h10, 32'h22, 3'b001, 1'b0, 1'b0};
      vecs[4]  = '{2'b10, 3'b100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd0, 1'b1,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 3'b100, 1'b1, 1'b0};
      vecs[5]  = '{2'b11, 3'b110, 1'b1, 1'b1, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFFF, 32'd2,
                   32'h8000_0001, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   32'hFFFF_FFFF, 32'h8000_0001, 3'b011, 1'b0, 1'b1};
      vecs[6]  = '{2'b11, 3'b000, 1'b1, 1'b1, 5'd4, 5'd0, 5'd11, 32'h1234, 32'd0,
                   32'hFFFF_FFF0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   32'h1234, 32'hFFFF_FFF0, 3'b000, 1'b0, 1'b1};
      vecs[7]  = '{2'b10, 3'b111, 1'b0, 1'b0, 5'd4, 5'd5, 5'd12, 32'hF0F0, 32'h0FF0, 32'd0,
                   1'b1, 1'b1, 5'd5, 32'hABCD, 1'b1, 5'd5, 32'h1, 32'hF0F0, 32'hABCD,
                   3'b010, 1'b0, 1'b1};
      vecs[8]  = '{2'b10, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd13, 32'd3, 32'd7, 32'd0, 1'b1,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd3, 32'd7, 3'b101, 1'b0, 1'b1};
      vecs[9]  = '{2'b11, 3'b001, 1'b0, 1'b1, 5'd1, 5'd2, 5'd14, 32'd3, 32'd7, 32'd5, 1'b1,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd3, 32'd5, 3'b100, 1'b1, 1'b0};
      vecs[10] = '{2'b10, 3'b000, 1'b0, 1'b0, 5'd7, 5'd7, 5'd15, 32'd1, 32'd2, 32'd0, 1'b1,
                   1'b1, 5'd8, 32'h11, 1'b1, 5'd7, 32'h22, 32'h22, 32'h22, 3'b000, 1'b0, 1'b1};

      reset = 1'b1;  flush = 1'b0;  out_ready = 1'b0;
      drive_simple(32'd0, 5'd0);
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset a", a, 32'd0);
      check("reset b", b, 32'd0);
      check("reset op/rd/rw", 32'({aluoperation, out_rd, out_regwrite, illegal}), 32'd0);

      // Back-to-back vectors: each edge fires the previous entry and loads the next.
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         apply(vecs[i]);
         tick();
         in_valid = 1'b0;
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("vec%0d a", i), a, vecs[i].exp_a);
         check($sformatf("vec%0d b", i), b, vecs[i].exp_b);
         check($sformatf("vec%0d op/ill/rw", i),
               32'({aluoperation, illegal, out_regwrite}),
               32'({vecs[i].exp_op, vecs[i].exp_ill, vecs[i].exp_rw}));
         check($sformatf("vec%0d rd", i), 32'(out_rd), 32'(vecs[i].rd));
      end
      tick();
      check("drain out_valid", 32'(out_valid), 32'd0);

      // Backpressure: three instructions with out_ready low.
      out_ready = 1'b0;
      drive_simple(32'hA1, 5'd21);
      tick();
      check("bp first accept in_ready", 32'(in_ready), 32'd1);
      drive_simple(32'hA2, 5'd22);
      tick();
      check("bp full in_ready", 32'(in_ready), 32'd0);
      drive_simple(32'hA3, 5'd23);
      tick();
      check("bp held a", a, 32'hA1);
      check("bp held in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp second a", a, 32'hA2);
      check("bp second rd", 32'(out_rd), 32'd22);
      check("bp reopen in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp third a", a, 32'hA3);
      check("bp third valid", 32'(out_valid), 32'd1);
      tick();
      check("bp drained", 32'(out_valid), 32'd0);

      // Flush in TWO with an incoming instruction.
      out_ready = 1'b0;
      drive_simple(32'hB1, 5'd24);
      tick();
      drive_simple(32'hB2, 5'd25);
      tick();
      check("flush pre in_ready", 32'(in_ready), 32'd0);
      drive_simple(32'hB3, 5'd26);
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush out_valid", 32'(out_valid), 32'd0);
      check("flush out_regwrite", 32'(out_regwrite), 32'd0);
      check("flush in_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      check("flush no ghost", 32'(out_valid), 32'd0);

      // Reset with both entries held.
      out_ready = 1'b0;
      drive_simple(32'hC1, 5'd27);
      tick();
      drive_simple(32'hC2, 5'd28);
      tick();
      in_valid = 1'b0;
      check("rst pre out_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b1;
      tick();
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst a", a, 32'd0);
      check("rst b", b, 32'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      check("rst stays empty", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
